// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the IF/ID payload type for the MIPS front end.
package pipe_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [5:0]  OP_J             = 6'h02;
    localparam logic [5:0]  OP_BEQ           = 6'h04;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    // Redirect targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Control, imem and IF/ID signals between the fetch stage and the rest of the pipe.
interface fetch_stage_if #(parameter int CNT_W = 32);
    logic             Stall;
    logic             BranchTaken;
    logic [31:0]      BranchTarget;
    logic             Jump;
    logic [31:0]      JumpTarget;
    logic [31:0]      ImemAddr;
    logic [31:0]      ImemData;
    logic [31:0]      InstructionOut;
    logic [31:0]      PCPlus4Out;
    logic             ValidOut;
    logic [CNT_W-1:0] FetchCount;

    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, ImemData,
        input  ImemAddr, InstructionOut, PCPlus4Out, ValidOut, FetchCount
    );
    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, ImemData,
        output ImemAddr, InstructionOut, PCPlus4Out, ValidOut, FetchCount
    );
endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: Reset > Flush (insert NOP) > Hold > load.
module if_id_pipe_reg
    import pipe_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset,
    input  logic   Hold,
    input  logic   Flush,
    input  if_id_t i_d,
    output if_id_t o_q
);
    if_id_t r_q;

    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            r_q.instr <= NOP_INSTR;
            r_q.pc4   <= '0;
            r_q.valid <= 1'b0;
        end else if (!Hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register, next-PC priority mux, IF/ID register, fetch counter.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    fetch_stage_if.slave  bus
);
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_fetch_count;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_pc_next;
    logic             w_flush;
    logic             w_fetch;
    if_id_t           w_if_id_d;
    if_id_t           w_if_id_q;

    assign w_pc_plus4 = r_pc + PC_STEP;

    // Branch beats stall (the stalled ID op is younger); stall masks jump.
    assign w_flush = bus.BranchTaken || (bus.Jump && !bus.Stall);
    assign w_fetch = !bus.BranchTaken && !bus.Stall && !bus.Jump;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (bus.BranchTaken)
            w_pc_next = word_align(bus.BranchTarget);
        else if (bus.Stall)
            w_pc_next = r_pc;
        else if (bus.Jump)
            w_pc_next = word_align(bus.JumpTarget);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_fetch)
                r_fetch_count <= r_fetch_count + CNT_W'(1);
        end
    end

    assign w_if_id_d.instr = bus.ImemData;
    assign w_if_id_d.pc4   = w_pc_plus4;
    assign w_if_id_d.valid = 1'b1;

    if_id_pipe_reg u_if_id (
        .Clk   (Clk),
        .Reset (Reset),
        .Hold  (bus.Stall),
        .Flush (w_flush),
        .i_d   (w_if_id_d),
        .o_q   (w_if_id_q)
    );

    assign bus.ImemAddr       = r_pc;
    assign bus.InstructionOut = w_if_id_q.instr;
    assign bus.PCPlus4Out     = w_if_id_q.pc4;
    assign bus.ValidOut       = w_if_id_q.valid;
    assign bus.FetchCount     = r_fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a model-fed expectation queue.
module tb_fetch_stage;
    import pipe_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    fetch_stage_if #(.CNT_W(32)) ifa ();
    fetch_stage_if #(.CNT_W(32)) ifb ();

    assign ifa.ImemData = 32'h1000_0000 + (ifa.ImemAddr >> 2);
    assign ifb.ImemData = ifb.ImemAddr;

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(ifa));
    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(32)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(ifb));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Drive one cycle, push the expected post-edge state, then pop and compare it.
    task automatic step(input logic rst, input logic st, input logic br,
                        input logic [31:0] bt, input logic j, input logic [31:0] jt);
        exp_t e;
        Reset            = rst;
        ifa.Stall        = st;
        ifa.BranchTaken  = br;
        ifa.BranchTarget = bt;
        ifa.Jump         = j;
        ifa.JumpTarget   = jt;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_v = 1'b0; m_cnt = 32'h0;
        end else if (br) begin
            m_pc = {bt[31:2], 2'b00}; m_instr = 32'h0; m_pc4 = 32'h0; m_v = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (j) begin
            m_pc = {jt[31:2], 2'b00}; m_instr = 32'h0; m_pc4 = 32'h0; m_v = 1'b0;
        end else begin
            m_instr = 32'h1000_0000 + (m_pc >> 2);
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc4;
            m_v     = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.cnt = m_cnt; e.v = m_v;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("ImemAddr",       ifa.ImemAddr,       e.pc);
            chk("InstructionOut", ifa.InstructionOut, e.instr);
            chk("PCPlus4Out",     ifa.PCPlus4Out,     e.pc4);
            chk("ValidOut",       {31'b0, ifa.ValidOut}, {31'b0, e.v});
            chk("FetchCount",     ifa.FetchCount,     e.cnt);
        end
    endtask

    initial begin
        ifb.Stall = 1'b0; ifb.BranchTaken = 1'b0; ifb.BranchTarget = 32'h0;
        ifb.Jump  = 1'b0; ifb.JumpTarget  = 32'h0;

        // Reset then four free fetches; dut_b checks PC wrap from FFFF_FFF8.
        step(1, 0, 0, 0, 0, 0);
        chk("rst_valid", {31'b0, ifa.ValidOut}, 32'h0);
        chk("b_addr0", ifb.ImemAddr, 32'hFFFF_FFF8);
        step(0, 0, 0, 0, 0, 0);
        chk("b_addr1", ifb.ImemAddr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        chk("b_addr2_wrap", ifb.ImemAddr, 32'h0000_0000);
        chk("b_pc4_wrap", ifb.PCPlus4Out, 32'h0000_0000);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_count", ifa.FetchCount, 32'd4);
        chk("t1_pc4", ifa.PCPlus4Out, 32'd16);
        chk("t1_instr", ifa.InstructionOut, 32'h1000_0003);

        // Stall two cycles at PC=8, then resume with no gap or duplicate.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("t2_hold_pc", ifa.ImemAddr, 32'd8);
        chk("t2_hold_cnt", ifa.FetchCount, 32'd2);
        step(0, 0, 0, 0, 0, 0);
        chk("t2_resume_instr", ifa.InstructionOut, 32'h1000_0002);
        step(0, 0, 0, 0, 0, 0);

        // Branch at PC=16.
        step(0, 0, 1, 32'h40, 0, 0);
        chk("t3_br_pc", ifa.ImemAddr, 32'h40);
        chk("t3_br_cnt", ifa.FetchCount, 32'd4);
        step(0, 0, 0, 0, 0, 0);

        // Stall+branch: branch wins. Stall+jump: jump ignored.
        step(0, 1, 1, 32'h80, 0, 0);
        chk("t4_sb_pc", ifa.ImemAddr, 32'h80);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h200);
        chk("t4_sj_pc", ifa.ImemAddr, 32'h84);
        chk("t4_sj_valid", {31'b0, ifa.ValidOut}, 32'h1);
        step(0, 0, 0, 0, 1, 32'h203);
        chk("t4_jmp_align", ifa.ImemAddr, 32'h200);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h302, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset during a stall with a valid IF/ID entry.
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h500, 1, 32'h600);
        chk("t6_pc", ifa.ImemAddr, 32'h0);
        chk("t6_valid", {31'b0, ifa.ValidOut}, 32'h0);
        chk("t6_instr", ifa.InstructionOut, 32'h0);
        chk("t6_cnt", ifa.FetchCount, 32'h0);
        step(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
